lsu_pipe_fu: RTL

//  Parametrised load/store FU between the LSU reservation station and a fixed-latency BRAM-style DMEM.

---
 rtl/lsu_pipe_fu.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_pipe_fu.sv
// Pipelined load/store FU: DMEM requests with fixed latency, flushable metadata and a credit-limited response FIFO.
// Optional LSU_MISALIGN_EXC_EN: misaligned H/W accesses skip DMEM and complete with wb_exc_o set.

package lsu_pipe_fu_pkg;
  localparam int TAG_W = 5;
  localparam int PRD_W = 6;

  typedef enum logic [1:0] {LS_B = 2'd0, LS_H = 2'd1, LS_W = 2'd2} ls_size_t;

  typedef struct packed {
    logic             is_load;
    logic             is_store;
    ls_size_t         ls_size;
    logic             unsigned_load;
    logic [31:0]      imm;
    logic [TAG_W-1:0] rob_tag;
    logic [PRD_W-1:0] prd;
    logic             rd_used;
  } rs_entry_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rob_tag;
    logic             rd_used;
    logic [PRD_W-1:0] prd;
    logic [31:0]      data;
  } wb_pkt_t;
endpackage

module lsu_pipe_fu
  import lsu_pipe_fu_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  rs_entry_t   entry_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        dmem_en_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  output ls_size_t    dmem_size_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output wb_pkt_t     wb_o,
  input  logic        wb_ready_i,
  output logic        wb_exc_o
);

  typedef struct packed {
    logic             v;
    logic             is_load;
    logic             rd_used;
    logic [TAG_W-1:0] rob_tag;
    logic [PRD_W-1:0] prd;
    ls_size_t         size;
    logic             uns;
    logic [1:0]       off;
    logic             exc;
  } meta_t;

  typedef struct packed {
    logic    exc;
    wb_pkt_t pkt;
  } resp_t;

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + MEM_LAT + 1);

  meta_t            meta_q [MEM_LAT];
  meta_t            meta_d [MEM_LAT];
  resp_t            fifo_q [RESP_DEPTH];
  resp_t            fifo_d [RESP_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, outstanding;

  logic [31:0] addr, load_data;
  logic        misalign, accept, resp_valid, fifo_empty, push, pop;
  meta_t       last;
  resp_t       resp;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign addr = src1_i + entry_i.imm;

`ifdef LSU_MISALIGN_EXC_EN
  assign misalign = (entry_i.ls_size == LS_H && addr[0]) ||
                    (entry_i.ls_size == LS_W && addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Credits cover every request still in the pipe plus every parked response.
  always_comb begin
    outstanding = cnt_q;
    for (int k = 0; k < MEM_LAT; k++) outstanding = outstanding + CNT_W'(meta_q[k].v);
  end

  assign issue_ready_o = rst_n && !flush_i && (outstanding < CNT_W'(RESP_DEPTH));
  assign accept        = issue_valid_i && issue_ready_o;
  assign dmem_en_o     = accept && !misalign;
  assign dmem_we_o     = entry_i.is_store;
  assign dmem_addr_o   = addr;
  assign dmem_size_o   = entry_i.ls_size;

  always_comb begin
    dmem_wdata_o = src2_i;
    dmem_be_o    = 4'b1111;
    case (entry_i.ls_size)
      LS_B: begin
        dmem_wdata_o = {4{src2_i[7:0]}};
        dmem_be_o    = 4'b0001 << addr[1:0];
      end
      LS_H: begin
        dmem_wdata_o = {2{src2_i[15:0]}};
        dmem_be_o    = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
  end

  assign last       = meta_q[MEM_LAT-1];
  assign resp_valid = last.v && !flush_i && (dmem_rvalid_i || last.exc);

  always_comb begin
    load_data = dmem_rdata_i;
    case (last.size)
      LS_B: begin
        load_data[31:8] = {24{dmem_rdata_i[{last.off, 3'b000} + 7] && !last.uns}};
        load_data[7:0]  = dmem_rdata_i[{last.off, 3'b000} +: 8];
      end
      LS_H: begin
        load_data[31:16] = {16{dmem_rdata_i[{last.off[1], 4'b0000} + 15] && !last.uns}};
        load_data[15:0]  = dmem_rdata_i[{last.off[1], 4'b0000} +: 16];
      end
      default: ;
    endcase
  end

  // Stores, excepting ops and loads without a destination all carry a zero result.
  always_comb begin
    resp             = '0;
    resp.pkt.valid   = 1'b1;
    resp.pkt.rob_tag = last.rob_tag;
    if (last.exc) begin
      resp.exc = 1'b1;
    end else if (last.is_load) begin
      resp.pkt.rd_used = last.rd_used;
      resp.pkt.prd     = last.prd;
      resp.pkt.data    = last.rd_used ? load_data : 32'd0;
    end
  end

  assign fifo_empty = (cnt_q == '0);
  assign push       = resp_valid && !(fifo_empty && wb_ready_i);
  assign pop        = !fifo_empty && wb_ready_i && !flush_i;

  always_comb begin
    if (fifo_empty) begin
      wb_o       = resp.pkt;
      wb_o.valid = resp_valid;
      wb_exc_o   = resp.exc && resp_valid;
    end else begin
      wb_o       = fifo_q[rd_ptr_q].pkt;
      wb_o.valid = !flush_i;
      wb_exc_o   = fifo_q[rd_ptr_q].exc && !flush_i;
    end
  end

  always_comb begin
    meta_d[0] = '0;
    if (accept) begin
      meta_d[0].v       = 1'b1;
      meta_d[0].is_load = entry_i.is_load;
      meta_d[0].rd_used = entry_i.rd_used;
      meta_d[0].rob_tag = entry_i.rob_tag;
      meta_d[0].prd     = entry_i.prd;
      meta_d[0].size    = entry_i.ls_size;
      meta_d[0].uns     = entry_i.unsigned_load;
      meta_d[0].off     = addr[1:0];
      meta_d[0].exc     = misalign;
    end
    for (int k = 1; k < MEM_LAT; k++) meta_d[k] = meta_q[k-1];

    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = resp;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (flush_i) begin
      for (int k = 0; k < MEM_LAT; k++) meta_d[k] = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MEM_LAT; k++) meta_q[k] <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // A live request that reached the end of the pipe must see its fixed-latency response.
  a_rvalid_on_time: assert property (@(posedge clk) disable iff (!rst_n)
    (last.v && !last.exc) |-> dmem_rvalid_i);

endmodule
